// File: rtl/stg_pkg.sv
// Shared definitions for the shooter playfield and boss control blocks.
package stg_pkg;

  localparam int unsigned MAX_X = 384;
  localparam int unsigned MAX_Y = 448;

  typedef enum logic [2:0] {
    ST_ENTER,
    ST_PH1,
    ST_PH2,
    ST_PH3,
    ST_DEAD
  } boss_state_t;

  typedef enum logic [2:0] {
    PAT_NONE   = 3'd0,
    PAT_FAN    = 3'd1,
    PAT_RING   = 3'd2,
    PAT_SPIRAL = 3'd3
  } pattern_t;

  function automatic logic is_attack(input boss_state_t s);
    return (s == ST_PH1) || (s == ST_PH2) || (s == ST_PH3);
  endfunction

endpackage

// File: rtl/fire_sched.sv
// Per-phase fire period counter plus the single-entry req/ack register.
// A period that elapses while a request is still pending is dropped.
module fire_sched
  import stg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] period,
  input  pattern_t   pat,
  input  logic       phase_change,
  input  logic       ack,
  input  logic       kill,
  output logic       req,
  output pattern_t   pattern
);

  logic [7:0] cnt_q;
  logic       elapse;

  assign elapse = frame_tick && !phase_change && (period != '0) &&
                  (cnt_q == period - 8'd1);

  // Frame counter: cleared on phase entry, wraps at the phase period.
  always_ff @(posedge clk) begin
    if (!reset || phase_change || kill) begin
      cnt_q <= '0;
    end else if (frame_tick && (period != '0)) begin
      cnt_q <= elapse ? '0 : cnt_q + 8'd1;
    end
  end

  // Request register: ack clears, elapse raises only when idle.
  always_ff @(posedge clk) begin
    if (!reset || kill) begin
      req     <= 1'b0;
      pattern <= PAT_NONE;
    end else if (req && ack) begin
      req <= 1'b0;
    end else if (!req && elapse) begin
      req     <= 1'b1;
      pattern <= pat;
    end
  end

endmodule

// File: rtl/boss_phase_ctrl.sv
// Boss sequencer: entry descent, three attack phases with sweep/return
// motion, health with hit immunity, and fire request scheduling.
module boss_phase_ctrl
  import stg_pkg::*;
#(
  parameter int unsigned HOME_X        = 192,
  parameter int unsigned HOME_Y        = 100,
  parameter int unsigned X_MIN         = 64,
  parameter int unsigned X_MAX         = 320,
  parameter int unsigned LIFE_INIT     = 1000,
  parameter int unsigned P2_LIFE       = 500,
  parameter int unsigned P3_LIFE       = 200,
  parameter int unsigned FIRE_P1       = 60,
  parameter int unsigned FIRE_P2       = 30,
  parameter int unsigned FIRE_P3       = 15,
  parameter int unsigned INVULN_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       is_hit,
  input  logic       fire_ack,
  output logic [9:0] boss_x,
  output logic [9:0] boss_y,
  output logic [9:0] health,
  output logic [1:0] phase,
  output logic       invuln,
  output logic       fire_req,
  output logic [2:0] pattern_id,
  output logic       die
);

  localparam logic [9:0] HX  = 10'(HOME_X);
  localparam logic [9:0] HY  = 10'(HOME_Y);
  localparam logic [9:0] XL  = 10'(X_MIN);
  localparam logic [9:0] XH  = 10'(X_MAX);
  localparam logic [9:0] LI  = 10'(LIFE_INIT);
  localparam logic [9:0] L2  = 10'(P2_LIFE);
  localparam logic [9:0] L3  = 10'(P3_LIFE);
  localparam logic [7:0] INV = 8'(INVULN_FRAMES);

  boss_state_t state_q, state_d;
  logic [7:0]  inv_cnt_q;
  logic        dir_left_q;
  logic [9:0]  step;
  logic [9:0]  sweep_x;
  logic        sweep_left;
  logic        hit_ok;
  logic [7:0]  period_sel;
  pattern_t    pat_sel;
  pattern_t    fire_pat;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_ENTER;
    else        state_q <= state_d;
  end

  // Next state: entry ends on the tick reaching HOME_Y; attack phases follow registered health.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ENTER: if (frame_tick && (boss_y == HY - 10'd1)) state_d = ST_PH1;
      ST_PH1, ST_PH2, ST_PH3: begin
        if (health == '0)                         state_d = ST_DEAD;
        else if (health <= L3)                    state_d = ST_PH3;
        else if (health <= L2 && state_q == ST_PH1) state_d = ST_PH2;
      end
      ST_DEAD: state_d = ST_DEAD;
      default: state_d = ST_ENTER;
    endcase
  end

  // Sweep step with clamp-and-reverse at the horizontal bounds.
  always_comb begin
    step       = (state_q == ST_PH2) ? 10'd2 : 10'd1;
    sweep_x    = boss_x;
    sweep_left = dir_left_q;
    if (!dir_left_q) begin
      if (boss_x + step >= XH) begin
        sweep_x    = XH;
        sweep_left = 1'b1;
      end else begin
        sweep_x = boss_x + step;
      end
    end else begin
      if (boss_x <= XL + step) begin
        sweep_x    = XL;
        sweep_left = 1'b0;
      end else begin
        sweep_x = boss_x - step;
      end
    end
  end

  assign hit_ok = is_hit && is_attack(state_q) && (inv_cnt_q == '0);

  // Position, direction, health and immunity counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      boss_x     <= HX;
      boss_y     <= '0;
      health     <= LI;
      inv_cnt_q  <= '0;
      dir_left_q <= 1'b0;
    end else begin
      if (frame_tick) begin
        unique case (state_q)
          ST_ENTER: boss_y <= boss_y + 10'd1;
          ST_PH1, ST_PH2: begin
            boss_x     <= sweep_x;
            dir_left_q <= sweep_left;
          end
          ST_PH3: begin
            if (boss_x < HX)      boss_x <= boss_x + 10'd1;
            else if (boss_x > HX) boss_x <= boss_x - 10'd1;
          end
          default: ;
        endcase
      end
      // A hit coinciding with a tick reloads the counter rather than decrementing it.
      if (hit_ok) begin
        if (health != '0) health <= health - 10'd1;
        inv_cnt_q <= INV;
      end else if (frame_tick && (inv_cnt_q != '0)) begin
        inv_cnt_q <= inv_cnt_q - 8'd1;
      end
    end
  end

  // Period and pattern for the current phase; zero period disables firing.
  always_comb begin
    period_sel = '0;
    pat_sel    = PAT_NONE;
    phase      = 2'd0;
    unique case (state_q)
      ST_PH1: begin period_sel = 8'(FIRE_P1); pat_sel = PAT_FAN;    phase = 2'd1; end
      ST_PH2: begin period_sel = 8'(FIRE_P2); pat_sel = PAT_RING;   phase = 2'd2; end
      ST_PH3: begin period_sel = 8'(FIRE_P3); pat_sel = PAT_SPIRAL; phase = 2'd3; end
      default: ;
    endcase
  end

  fire_sched u_fire (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .period       (period_sel),
    .pat          (pat_sel),
    .phase_change (state_d != state_q),
    .ack          (fire_ack),
    .kill         (state_d == ST_DEAD),
    .req          (fire_req),
    .pattern      (fire_pat)
  );

  assign pattern_id = fire_pat;
  assign invuln     = (inv_cnt_q != '0);
  assign die        = (state_q == ST_DEAD);

endmodule

// File: doc/boss_phase_ctrl.md
Name: boss_phase_ctrl

Overview:
- Controller that sequences the boss sprite through entry, three attack phases and death.
- Owns boss position, health and invulnerability, and issues bullet-pattern fire requests to the bullet spawner over a req/ack handshake.
- Sits between the collision logic (hit pulses), the frame-tick generator, and the boss sprite renderer / bullet spawner (position and pattern outputs).
- Coordinates are playfield-relative: 384x448 field, boss anchor is the sprite centre.

Parameters:
- HOME_X, 192, x centre for entry and phase 3 rest
- HOME_Y, 100, y at which entry ends
- X_MIN, 64, left sweep bound
- X_MAX, 320, right sweep bound
- LIFE_INIT, 1000, initial health; must be ≤1023
- P2_LIFE, 500, health at or below which phase 2 starts
- P3_LIFE, 200, health at or below which phase 3 starts
- FIRE_P1, 60, frames between fire requests in phase 1
- FIRE_P2, 30, frames between fire requests in phase 2
- FIRE_P3, 15, frames between fire requests in phase 3
- INVULN_FRAMES, 2, frames of hit immunity after an accepted hit

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- is_hit  in  1  one-cycle pulse per player-bullet collision with boss
- fire_ack  in  1  spawner accepts current request
- boss_x  out  10  boss centre x
- boss_y  out  10  boss centre y
- health  out  10  remaining life
- phase  out  2  0=ENTER/DEAD, 1..3 attack phase
- invuln  out  1  hits currently ignored
- fire_req  out  1  fire request pending
- pattern_id  out  3  bullet pattern for current request
- die  out  1  boss defeated

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=ENTER, boss_x=HOME_X, boss_y=0, health=LIFE_INIT, phase=0.
  - invuln=0, fire_req=0, pattern_id=0, die=0; fire counter, invuln counter and sweep direction (right) cleared.
  - Reset mid-operation (including during DEAD or a pending request) fully restores these values next cycle; fire_req drops with no ack needed.
- All motion and frame counters advance only on cycles with frame_tick=1. Hit logic is evaluated every cycle.
- FSM states: ENTER, PH1, PH2, PH3, DEAD.
- ENTER:
  - boss_y+=1 per frame; hits ignored; no fire.
  - When boss_y reaches HOME_Y, go to PH1 on the same tick.
- PH1:
  - boss_x moves 1 px/frame in the current direction.
  - Direction reverses when the next x would reach or pass a bound; x is clamped to X_MIN/X_MAX.
- PH2: same sweep at 2 px/frame, with the same clamp rule (64→62 is clamped to 64).
- PH3: boss_x steps 1 px/frame toward HOME_X; stationary once equal.
- Phase transitions are evaluated every cycle on the registered health:
  - health≤P3_LIFE → PH3 (PH1 may jump directly to PH3).
  - else health≤P2_LIFE → PH2.
  - health==0 → DEAD, with priority over all other transitions.
- Hit handling:
  - is_hit is accepted when state∈{PH1,PH2,PH3} and invuln==0.
  - An accepted hit decrements health by 1 (saturating at 0) and loads the invuln counter with INVULN_FRAMES; invuln=1 while the counter is nonzero.
  - The invuln counter decrements per frame_tick.
  - If a hit and a frame_tick coincide, the hit takes effect and the counter is loaded, not decremented.
  - With INVULN_FRAMES=0, invuln never asserts.
  - The threshold crossing is acted on in the cycle after the decrement.
- Fire scheduling:
  - A frame counter is cleared on every phase entry.
  - When it reaches the phase period, fire_req is raised with pattern_id = phase number (1..3), and the counter restarts.
  - fire_req and pattern_id stay stable until a cycle with fire_ack=1; fire_req drops the next cycle.
  - A period that elapses while fire_req is already high is dropped (no queue, pattern not updated).
  - A phase change while a request is pending keeps that request's pattern_id until ack.
  - fire_ack with fire_req=0 is ignored.
- DEAD:
  - die=1, phase=0, fire_req forced 0 immediately, position frozen, hits ignored.
  - Only reset exits DEAD.
- Outputs are all registered; position updates appear one cycle after the frame_tick.

Decomposition:
- Shared package stg_pkg holds:
  - playfield constants (MAX_X=384, MAX_Y=448)
  - boss FSM state encoding
  - pattern_id enumeration (PAT_NONE=0, PAT_FAN=1, PAT_RING=2, PAT_SPIRAL=3)
- One natural sub-module, fire_sched, holds the period counter, the req/ack register and drop logic. Inputs: frame_tick, period, phase_change, ack, kill.

Test Plan:
- Reset, then 100 frame_ticks → boss_y steps 0..100, boss_x=192. At tick 100, state=PH1, phase=1; is_hit pulses during ENTER leave health=1000.
- In PH1, hold direction right from x=318 for 4 ticks → x=319,320,319,318. No x value exceeds 320.
- Inject 500 accepted hits (wait 2 frames between each) → phase=2 one cycle after health reads 500. First fire_req appears after 30 ticks with pattern_id=2.
- Hold fire_ack=0 for 70 ticks in PH2 → fire_req stays high, pattern_id=2, no extra request. fire_ack=1 → fire_req=0 next cycle, and the next request comes 30 ticks after the last period boundary.
- Two is_hit pulses within the same invuln window → health decrements by 1 only.
- Drive health to 0 while fire_req=1 → die=1, fire_req=0 the same state entry, and position frozen. Assert reset=0 for one cycle → health=1000, boss_y=0, die=0.
